// File: rtl/m_ucode_loader.sv
// Microcode store writer: packs a byte stream into 48-bit words,
// writes them to the ucode RAM and verifies a trailing XOR checksum.
module m_ucode_loader #(
    parameter int NWORDS = 256,
    parameter int BPW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        we,
    output logic [7:0]  waddr,
    output logic [47:0] wdata,
    output logic        ucode_hold,
    output logic        done,
    output logic        err
);

    generate
        if (BPW != 6) begin : g_bad_bpw
            $error("m_ucode_loader: BPW must be 6");
        end
        if (NWORDS < 1 || NWORDS > 256) begin : g_bad_nwords
            $error("m_ucode_loader: NWORDS must be 1..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(NWORDS - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [47:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        rdy_q, rdy_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        accept;

    assign accept = din_valid & rdy_q;

    // Next-state logic; din_ready drops during the final write so the
    // checksum byte cannot land in the word lanes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        rdy_d   = rdy_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    waddr_d = 8'd0;
                    cnt_d   = 3'd0;
                    acc_d   = 8'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    rdy_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (we_q) begin
                    waddr_d = waddr_q + 8'd1;
                    if (waddr_q == LAST) begin
                        state_d = S_CHECK;
                        rdy_d   = 1'b1;
                    end
                end
                if (accept) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = din;
                    acc_d = acc_q ^ din;
                    if (cnt_q == 3'd5) begin
                        cnt_d = 3'd0;
                        we_d  = 1'b1;
                        if (waddr_q == LAST) begin
                            rdy_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    err_d   = (din != acc_q);
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            acc_q   <= 8'd0;
            waddr_q <= 8'd0;
            wdata_q <= 48'd0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign din_ready  = rdy_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign ucode_hold = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
